// File: rtl/weight_stream_rearrange.sv
// Buffers one layer of filter-major bfloat16 weights in PE-banked storage, then
// replays them as a transposed stream with PE_LANES filters per beat.
module weight_stream_rearrange #(
  parameter int K_MAX    = 16,
  parameter int C_MAX    = 8,
  parameter int WH_MAX   = 5,
  parameter int PE_LANES = 4,
  parameter int BW       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(K_MAX+1)-1:0]    cfg_k,
  input  logic [$clog2(C_MAX+1)-1:0]    cfg_c,
  input  logic [$clog2(WH_MAX+1)-1:0]   cfg_wh,
  input  logic                          cfg_rot180,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BW-1:0]                 in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PE_LANES*BW-1:0]        out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);
  localparam int KW        = $clog2(K_MAX+1);
  localparam int KW1       = KW + 1;
  localparam int CW        = $clog2(C_MAX+1);
  localparam int WW        = $clog2(WH_MAX+1);
  localparam int LOG2PE    = $clog2(PE_LANES);
  localparam int TILES_MAX = (K_MAX + PE_LANES - 1) / PE_LANES;
  localparam int DEPTH     = TILES_MAX * C_MAX * WH_MAX * WH_MAX;
  localparam int AW        = $clog2(DEPTH);
  localparam int TW        = $clog2(TILES_MAX+1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            kCfg_q, k_q;
  logic [CW-1:0]            cCfg_q, ch_q;
  logic [WW-1:0]            whCfg_q, row_q, col_q;
  logic                     rot_q;
  logic [AW-1:0]            len_q, jd_q;
  logic [TW-1:0]            tiles_q, tile_q;
  logic                     issued_q;
  logic                     outValid_q, outLast_q, done_q, cfgErr_q;
  logic [PE_LANES*BW-1:0]   outData_q;
  logic [BW-1:0]            mem [PE_LANES][DEPTH];

  logic                     legal, startOk, inFire, lastIn, outFire, loadEn, issueLast;
  logic [KW:0]              kRound;
  logic [AW-1:0]            rowEff, colEff, wrAddr, rdAddr;
  logic [LOG2PE-1:0]        wrBank;
  logic [PE_LANES*BW-1:0]   rdData;

  assign legal     = (cfg_k != '0) && (cfg_k <= KW'(K_MAX)) &&
                     (cfg_c != '0) && (cfg_c <= CW'(C_MAX)) &&
                     (cfg_wh != '0) && (cfg_wh <= WW'(WH_MAX));
  assign startOk   = (state_q == IDLE) && start && legal;
  assign inFire    = (state_q == LOAD) && in_valid;
  assign lastIn    = inFire && (k_q == kCfg_q - KW'(1)) && (ch_q == cCfg_q - CW'(1)) &&
                     (row_q == whCfg_q - WW'(1)) && (col_q == whCfg_q - WW'(1));
  assign outFire   = outValid_q && out_ready;
  assign loadEn    = !outValid_q || out_ready;
  assign issueLast = (tile_q == tiles_q - TW'(1)) && (jd_q == len_q - AW'(1));
  assign kRound    = {1'b0, cfg_k} + KW1'(PE_LANES - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startOk) state_d = LOAD;
      LOAD:    if (lastIn) state_d = DRAIN;
      DRAIN:   if (outFire && outLast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == LOAD);
    busy     = (state_q != IDLE);
  end

  // Rotation mirrors row and column inside each channel plane at write time.
  always_comb begin
    rowEff = AW'(row_q);
    colEff = AW'(col_q);
    if (rot_q) begin
      rowEff = AW'(whCfg_q) - AW'(row_q) - AW'(1);
      colEff = AW'(whCfg_q) - AW'(col_q) - AW'(1);
    end
    wrAddr = AW'(k_q >> LOG2PE) * len_q + AW'(ch_q) * AW'(whCfg_q) * AW'(whCfg_q) +
             rowEff * AW'(whCfg_q) + colEff;
    wrBank = k_q[LOG2PE-1:0];
    rdAddr = AW'(tile_q) * len_q + jd_q;
  end

  always_comb begin
    rdData = '0;
    for (int p = 0; p < PE_LANES; p++) begin
      if ((int'(tile_q) * PE_LANES + p) < int'(kCfg_q)) rdData[p*BW +: BW] = mem[p][rdAddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && inFire) mem[wrBank][wrAddr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kCfg_q  <= '0;
      cCfg_q  <= '0;
      whCfg_q <= '0;
      rot_q   <= 1'b0;
      len_q   <= '0;
      tiles_q <= '0;
      k_q     <= '0;
      ch_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else if (startOk) begin
      kCfg_q  <= cfg_k;
      cCfg_q  <= cfg_c;
      whCfg_q <= cfg_wh;
      rot_q   <= cfg_rot180;
      len_q   <= AW'(cfg_c) * AW'(cfg_wh) * AW'(cfg_wh);
      tiles_q <= TW'(kRound >> LOG2PE);
      k_q     <= '0;
      ch_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else if (lastIn) begin
      k_q   <= '0;
      ch_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (inFire) begin
      if (col_q == whCfg_q - WW'(1)) begin
        col_q <= '0;
        if (row_q == whCfg_q - WW'(1)) begin
          row_q <= '0;
          if (ch_q == cCfg_q - CW'(1)) begin
            ch_q <= '0;
            k_q  <= k_q + KW'(1);
          end else begin
            ch_q <= ch_q + CW'(1);
          end
        end else begin
          row_q <= row_q + WW'(1);
        end
      end else begin
        col_q <= col_q + WW'(1);
      end
    end
  end

  // Output register doubles as the skid point: it only reloads when empty or being taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outData_q  <= '0;
      done_q     <= 1'b0;
      cfgErr_q   <= 1'b0;
      tile_q     <= '0;
      jd_q       <= '0;
      issued_q   <= 1'b0;
    end else begin
      done_q   <= (state_q == DRAIN) && outFire && outLast_q;
      cfgErr_q <= (state_q == IDLE) && start && !legal;
      if (startOk) begin
        tile_q   <= '0;
        jd_q     <= '0;
        issued_q <= 1'b0;
      end else if ((state_q == DRAIN) && loadEn) begin
        if (!issued_q) begin
          outData_q  <= rdData;
          outValid_q <= 1'b1;
          outLast_q  <= issueLast;
          if (issueLast) begin
            issued_q <= 1'b1;
          end else if (jd_q == len_q - AW'(1)) begin
            jd_q   <= '0;
            tile_q <= tile_q + TW'(1);
          end else begin
            jd_q <= jd_q + AW'(1);
          end
        end else begin
          outValid_q <= 1'b0;
          outLast_q  <= 1'b0;
        end
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_last  = outLast_q;
  assign out_data  = outData_q;
  assign done      = done_q;
  assign cfg_err   = cfgErr_q;
endmodule

// File: tb/tb_weight_stream_rearrange.sv
// Self-checking bench for weight_stream_rearrange: a reference model builds the expected
// transposed beat list straight from the filter/channel/row/col ordering rules.
module tb_weight_stream_rearrange;
  localparam int K_MAX = 16, C_MAX = 8, WH_MAX = 5, PE = 4, BW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, cfg_rot180, in_valid, out_ready;
  logic [4:0]    cfg_k;
  logic [3:0]    cfg_c;
  logic [2:0]    cfg_wh;
  logic [15:0]   in_data;
  logic          in_ready, out_valid, out_last, busy, done, cfg_err;
  logic [63:0]   out_data;

  weight_stream_rearrange #(.K_MAX(K_MAX), .C_MAX(C_MAX), .WH_MAX(WH_MAX), .PE_LANES(PE), .BW(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k), .cfg_c(cfg_c), .cfg_wh(cfg_wh),
    .cfg_rot180(cfg_rot180), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  logic [15:0] inData [3200];
  logic [63:0] expQ [800];
  int          expTotal, nIn, outIdx, stallPct;
  bit          checking, expectDone, doneSeen;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: place every input weight at its (tile, j, lane) slot.
  task automatic prepLayer(input int k, input int c, input int wh, input bit rot, input int mode);
    int L, T, n, jo, f;
    L = c * wh * wh;
    T = (k + PE - 1) / PE;
    nIn = k * L;
    expTotal = T * L;
    for (int i = 0; i < nIn; i++)
      inData[i] = (mode == 0) ? 16'(i + 1) : (mode == 1) ? 16'(i) : 16'($urandom);
    for (int i = 0; i < expTotal; i++) expQ[i] = '0;
    for (f = 0; f < k; f++)
      for (int ch = 0; ch < c; ch++)
        for (int r = 0; r < wh; r++)
          for (int col = 0; col < wh; col++) begin
            n  = ((f * c + ch) * wh + r) * wh + col;
            jo = ch * wh * wh + (rot ? (wh - 1 - r) * wh + (wh - 1 - col) : r * wh + col);
            expQ[(f / PE) * L + jo][(f % PE) * BW +: BW] = inData[n];
          end
  endtask

  task automatic checkReset();
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_out_data", out_data, 0);
  endtask

  task automatic startLayer(input int k, input int c, input int wh, input bit rot);
    outIdx = 0; doneSeen = 0; expectDone = 0;
    @(posedge clk); #1;
    start = 1; cfg_k = 5'(k); cfg_c = 4'(c); cfg_wh = 3'(wh); cfg_rot180 = rot;
    @(posedge clk); #1;
    start = 0;
    checking = 1;
    @(negedge clk);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_in_ready", in_ready, 1);
  endtask

  // Feeds beats from the negedge, with random gaps on in_valid.
  task automatic applyStimulus(input int count, input int gapPct, input bit full);
    int n = 0, guard = 0;
    while (n < count && guard < 50000) begin
      checkOutput("in_ready_load", in_ready, 1);
      in_valid = ($urandom_range(99) >= gapPct);
      in_data  = inData[n];
      @(posedge clk);
      if (in_valid) n++;
      @(negedge clk);
      guard++;
    end
    in_valid = 0;
    if (n < count) begin
      checks++; failures++;
      $display("[TB] FAIL load_timeout accepted=%0d required=%0d", n, count);
    end
    if (full) checkOutput("in_ready_drop", in_ready, 0);
  endtask

  task automatic finishLayer();
    int guard = 0;
    while (!doneSeen && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (!doneSeen) begin
      checks++; failures++;
      $display("[TB] FAIL drain_timeout beats=%0d required=%0d", outIdx, expTotal);
    end
    checkOutput("beats_seen", outIdx, expTotal);
    checkOutput("idle_out_valid", out_valid, 0);
    checking = 0;
  endtask

  task automatic runLayer(input int k, input int c, input int wh, input bit rot, input int gap, input int stall);
    stallPct = stall;
    startLayer(k, c, wh, rot);
    applyStimulus(nIn, gap, 1);
    finishLayer();
    stallPct = 0;
  endtask

  // Downstream stalls change just after each rising edge.
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      out_ready = (stallPct == 0) ? 1'b1 : ($urandom_range(99) >= stallPct);
    end
  end

  // Single compare process: every valid cycle must show the next expected beat.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        if (expectDone) begin
          checkOutput("done_pulse", done, 1);
          checkOutput("busy_after_done", busy, 0);
          doneSeen = 1;
          expectDone = 0;
        end else begin
          checkOutput("done_quiet", done, 0);
        end
        if (out_valid) begin
          if (outIdx >= expTotal) begin
            checks++; failures++;
            $display("[TB] FAIL extra_beat index=%0d required_total=%0d", outIdx, expTotal);
          end else begin
            checkOutput($sformatf("beat%0d_data", outIdx), out_data, expQ[outIdx]);
            checkOutput($sformatf("beat%0d_last", outIdx), out_last, (outIdx == expTotal - 1));
            if (out_ready) begin
              if (outIdx == expTotal - 1) expectDone = 1;
              outIdx++;
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 0; start = 0; cfg_k = 0; cfg_c = 0; cfg_wh = 0; cfg_rot180 = 0;
    in_valid = 0; in_data = 0; stallPct = 0; checking = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset();
    rst_n = 1;

    prepLayer(2, 1, 2, 0, 0);
    checkOutput("model_t1_total", expTotal, 4);
    checkOutput("model_t1_b0", expQ[0], 64'h0000_0000_0005_0001);
    checkOutput("model_t1_b3", expQ[3], 64'h0000_0000_0008_0004);
    runLayer(2, 1, 2, 0, 0, 0);

    prepLayer(2, 1, 2, 1, 0);
    checkOutput("model_rot_b0", expQ[0], 64'h0000_0000_0008_0004);
    checkOutput("model_rot_b3", expQ[3], 64'h0000_0000_0005_0001);
    runLayer(2, 1, 2, 1, 0, 0);

    prepLayer(5, 2, 3, 0, 1);
    checkOutput("model_k5_total", expTotal, 36);
    checkOutput("model_k5_b0", expQ[0], 64'h0036_0024_0012_0000);
    checkOutput("model_k5_b18", expQ[18], 64'd72);
    checkOutput("model_k5_b35", expQ[35], 64'd89);
    runLayer(5, 2, 3, 0, 0, 0);
    runLayer(5, 2, 3, 0, 35, 45);

    @(negedge clk);
    start = 1; cfg_k = 2; cfg_c = 1; cfg_wh = 0;
    @(posedge clk); #1; start = 0;
    @(negedge clk);
    checkOutput("err_wh0_pulse", cfg_err, 1);
    checkOutput("err_wh0_busy", busy, 0);
    @(negedge clk);
    checkOutput("err_wh0_clear", cfg_err, 0);
    start = 1; cfg_k = 5'(K_MAX + 1); cfg_wh = 2;
    @(posedge clk); #1; start = 0;
    @(negedge clk);
    checkOutput("err_k17_pulse", cfg_err, 1);
    checkOutput("err_k17_busy", busy, 0);
    @(negedge clk);
    checkOutput("err_k17_clear", cfg_err, 0);
    prepLayer(3, 1, 2, 0, 2);
    runLayer(3, 1, 2, 0, 0, 0);

    prepLayer(8, 2, 2, 0, 2);
    startLayer(8, 2, 2, 0);
    applyStimulus(3, 0, 0);
    checking = 0;
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    checkReset();
    rst_n = 1;
    prepLayer(3, 2, 2, 1, 2);
    runLayer(3, 2, 2, 1, 20, 20);

    for (int i = 0; i < 4; i++) begin
      int k, c, wh;
      bit rot;
      k = $urandom_range(K_MAX, 1);
      c = $urandom_range(C_MAX, 1);
      wh = $urandom_range(WH_MAX, 1);
      rot = 1'($urandom_range(1, 0));
      prepLayer(k, c, wh, rot, 2);
      runLayer(k, c, wh, rot, $urandom_range(40, 0), $urandom_range(50, 0));
    end

    prepLayer(K_MAX, C_MAX, WH_MAX, 1, 2);
    runLayer(K_MAX, C_MAX, WH_MAX, 1, 10, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/weight_stream_rearrange.md
# weight_stream_rearrange

Streaming, run-time-configurable weight rearranger for the GEMM datapath. It accepts one bfloat16 weight per beat in filter-major order (k, c, row, col) and buffers a full layer's filter set in PE-banked storage. It then drains the weights as a GEMM-ready transposed stream: each output beat holds flattened index j for PE_LANES consecutive filters. An optional 180° kernel rotation supports transposed-convolution and backprop use.

## Interface
- K_MAX, 16, maximum filters per layer
- C_MAX, 8, maximum channels per filter
- WH_MAX, 5, maximum square kernel size
- PE_LANES, 4, filters per output beat; power of 2
- BW, 16, word width (bfloat16)

Ports (clock and reset first):
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a layer; sampled only in IDLE
- cfg_k  in  $clog2(K_MAX+1)  filter count; latched on accepted start
- cfg_c  in  $clog2(C_MAX+1)  channel count; latched on accepted start
- cfg_wh  in  $clog2(WH_MAX+1)  kernel size; latched on accepted start
- cfg_rot180  in  1  rotate each kernel 180°; latched on accepted start
- in_valid  in  1  weight beat valid
- in_ready  out  1  weight beat accepted when in_valid & in_ready
- in_data  in  BW  weight value
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  PE_LANES*BW  lane p in bits [p*BW +: BW]
- out_last  out  1  final beat of the layer
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse on last accepted output beat
- cfg_err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, LOAD, DRAIN.
- IDLE → LOAD on start when all config legal: 1 ≤ cfg_k ≤ K_MAX, 1 ≤ cfg_c ≤ C_MAX, 1 ≤ cfg_wh ≤ WH_MAX.
  - Illegal config: stay in IDLE, pulse cfg_err next cycle.
  - start outside IDLE is ignored.
- Definitions: L = cfg_c·cfg_wh·cfg_wh; T = ceil(cfg_k / PE_LANES).
- LOAD: in_ready = 1. Nested counters col → row → ch → k advance per accepted beat, col fastest.
  - Storage bank = k mod PE_LANES.
  - Address = (k / PE_LANES)·L + j.
  - j = ch·wH² + row·wH + col; with cfg_rot180, j = ch·wH² + (wH−1−row)·wH + (wH−1−col).
- After the beat with k = cfg_k−1, ch = cfg_c−1, row = col = cfg_wh−1 is accepted: LOAD → DRAIN; in_ready drops the next cycle.
- DRAIN: tile t = 0..T−1 outer, j = 0..L−1 inner; T·L beats total.
  - Lane p carries filter t·PE_LANES + p at index j.
  - Lanes with filter index ≥ cfg_k output 16'h0000.
  - out_last = 1 on the beat with t = T−1, j = L−1.
  - That beat's acceptance pulses done and returns the block to IDLE.
- Storage is never cleared; contents are don't-care outside DRAIN.
- Counter and address arithmetic is unsigned and sized for K_MAX·C_MAX·WH_MAX² without overflow.

## Timing
- Reset (rst_n = 0 at a clock edge): state = IDLE; in_ready, out_valid, out_last, busy, done, cfg_err = 0; out_data = 0; all counters = 0.
- Reset mid-LOAD or mid-DRAIN aborts immediately; the partial layer is discarded.
- start accepted at cycle n → busy and in_ready high in cycle n+1.
- Final input beat accepted in cycle m → in_ready = 0 in m+1.
  - First out_valid in m+2, registered from combinational bank read.
- Output register loads when !out_valid | out_ready.
  - Sustained throughput: one beat per cycle with out_ready held high.
  - While out_valid & !out_ready, out_data and out_last are held stable.
- done asserts in the cycle after the last handshake; busy = 0 in the same cycle.
- in_valid during DRAIN or IDLE is ignored (in_ready = 0).
- Minimum layer latency: 1 + cfg_k·L + 1 + T·L cycles.

## Test plan
- K=2, C=1, wH=2, PE_LANES=4, no rotation; inputs 1..8 → 4 beats, lanes: {1,5,0,0}, {2,6,0,0}, {3,7,0,0}, {4,8,0,0}. out_last on beat 4, then done.
- Same config with cfg_rot180 = 1 → {4,8,0,0}, {3,7,0,0}, {2,6,0,0}, {1,5,0,0}.
- K=5, C=2, wH=3, PE_LANES=4; input value = linear beat index → 36 beats.
  - Tile 1 lane 0 = filter 4 values; lanes 1–3 = 0.
  - out_last only on beat 36.
- Random in_valid gaps and random out_ready stalls on the K=5 case.
  - Identical output sequence.
  - out_data stable during stalls; no lost or duplicated beats.
- start with cfg_wh = 0, then cfg_k = K_MAX+1 → cfg_err pulse each time; busy stays 0; next legal start succeeds.
- rst_n low mid-LOAD after 3 beats → all outputs at reset values. A fresh layer then drains correct data with no residue from the aborted layer.
